// File: rtl/i2s_rx_capture.sv
// I2S master receiver: generates sclk/ws from mclk and captures WIDTH-bit
// left/right samples into a held frame with valid/ready handoff and overrun flag.
module i2s_rx_capture #(
    parameter int WIDTH                = 16,
    parameter int MAIN_TO_SERIAL       = 24,
    parameter int SERIAL_TO_LEFT_RIGHT = 64
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             sd_rx,
    output logic             sclk,
    output logic             ws,
    output logic [WIDTH-1:0] rx_data_l,
    output logic [WIDTH-1:0] rx_data_r,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun
);

    localparam int HALF_M = MAIN_TO_SERIAL / 2;
    localparam int HALF_S = SERIAL_TO_LEFT_RIGHT / 2;
    localparam int HW     = (HALF_M > 1) ? $clog2(HALF_M) : 1;
    localparam int FW     = (HALF_S > 1) ? $clog2(HALF_S) : 1;
    localparam int SW     = $clog2(HALF_S + 1);

    logic [HW-1:0]    hcnt;
    logic [FW-1:0]    fcnt;
    logic [SW-1:0]    slot;
    logic [1:0]       sync;
    logic             armed;
    logic             done;
    logic [WIDTH-1:0] sh_l;
    logic [WIDTH-1:0] sh_r;

    logic hc_wrap, sclk_rise, sclk_fall, ws_tgl, in_slot;

    always_comb begin
        hc_wrap   = (hcnt == HW'(HALF_M - 1));
        sclk_rise = hc_wrap & ~sclk;
        sclk_fall = hc_wrap & sclk;
        ws_tgl    = sclk_fall & (fcnt == FW'(HALF_S - 1));
        in_slot   = (slot >= SW'(1)) && (slot <= SW'(WIDTH));
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            hcnt       <= '0;
            fcnt       <= '0;
            slot       <= '0;
            sync       <= '0;
            sclk       <= 1'b0;
            ws         <= 1'b0;
            armed      <= 1'b0;
            done       <= 1'b0;
            sh_l       <= '0;
            sh_r       <= '0;
            rx_data_l  <= '0;
            rx_data_r  <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            hcnt <= hc_wrap ? '0 : hcnt + HW'(1);
            if (hc_wrap)
                sclk <= ~sclk;
            sync <= {sync[0], sd_rx};

            if (sclk_fall)
                fcnt <= (fcnt == FW'(HALF_S - 1)) ? '0 : fcnt + FW'(1);

            // Frames only count once a left half has started cleanly after reset.
            if (ws_tgl) begin
                ws   <= ~ws;
                slot <= '0;
                if (ws)
                    armed <= 1'b1;
            end else if (sclk_rise) begin
                slot <= slot + SW'(1);
            end

            if (sclk_rise && in_slot) begin
                if (ws)
                    sh_r <= {sh_r[WIDTH-2:0], sync[1]};
                else
                    sh_l <= {sh_l[WIDTH-2:0], sync[1]};
            end

            done <= sclk_rise & ws & armed & (slot == SW'(WIDTH));

            // A load always wins over an accept; overrun only when nobody took the old frame.
            rx_overrun <= done & rx_valid & ~rx_ready;
            if (done) begin
                rx_data_l <= sh_l;
                rx_data_r <= sh_r;
            end
            rx_valid <= done | (rx_valid & ~rx_ready);
        end
    end

endmodule
